// File: rtl/seg7_ascii_capture.sv
// Decodes a debounced active-low 7-segment pattern bus to ASCII and queues it in a small FIFO.
// Optional macro DECODE_ERR_CNT_EN adds err_count, a saturating count of undecodable pushes.
module seg7_ascii_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [6:0]                 seg_in,
  input  logic                       seg_valid,
  output logic [7:0]                 ascii_out,
  output logic                       unknown,
  output logic                       ascii_valid,
  input  logic                       ascii_ready,
  output logic                       overflow,
  input  logic                       clr_overflow,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
`ifdef DECODE_ERR_CNT_EN
  ,
  output logic [7:0]                 err_count
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] StableLim = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StSettle, StLocked} state_e;

  // Returns {unknown, ascii}.
  function automatic logic [8:0] decode(input logic [6:0] p);
    logic [8:0] r;
    r = {1'b1, 8'h3F};
    unique case (p)
      7'h40: r = {1'b0, 8'h30};
      7'h79: r = {1'b0, 8'h31};
      7'h24: r = {1'b0, 8'h32};
      7'h30: r = {1'b0, 8'h33};
      7'h19: r = {1'b0, 8'h34};
      7'h12: r = {1'b0, 8'h35};
      7'h02: r = {1'b0, 8'h36};
      7'h78: r = {1'b0, 8'h37};
      7'h00: r = {1'b0, 8'h38};
      7'h10: r = {1'b0, 8'h39};
      7'h08: r = {1'b0, 8'h41};
      7'h03: r = {1'b0, 8'h42};
      7'h46: r = {1'b0, 8'h43};
      7'h21: r = {1'b0, 8'h44};
      7'h06: r = {1'b0, 8'h45};
      7'h0E: r = {1'b0, 8'h46};
      7'h09: r = {1'b0, 8'h48};
      7'h4F: r = {1'b0, 8'h49};
      7'h61: r = {1'b0, 8'h4A};
      7'h47: r = {1'b0, 8'h4C};
      7'h6A: r = {1'b0, 8'h4D};
      7'h2A: r = {1'b0, 8'h4E};
      7'h0C: r = {1'b0, 8'h50};
      7'h18: r = {1'b0, 8'h51};
      7'h2F: r = {1'b0, 8'h52};
      7'h07: r = {1'b0, 8'h54};
      7'h41: r = {1'b0, 8'h55};
      7'h63: r = {1'b0, 8'h56};
      7'h55: r = {1'b0, 8'h57};
      7'h11: r = {1'b0, 8'h59};
      7'h7F: r = {1'b0, 8'h20};
      default: r = {1'b1, 8'h3F};
    endcase
    return r;
  endfunction

  state_e     state_q, state_d;
  logic [6:0] cand_q, cand_d, last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       emitted_q, emitted_d;
  logic       push;
  logic [8:0] entry;

  assign entry = decode(cand_q);

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    emitted_d = emitted_q;
    push      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (seg_valid) begin
          cand_d  = seg_in;
          cnt_d   = 8'd1;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (seg_valid) begin
          if (seg_in == cand_q) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_d == StableLim) begin
              state_d   = StLocked;
              last_d    = cand_q;
              // Re-settling on the last accepted pattern (a short glitch) must not repeat it.
              push      = !emitted_q || (cand_q != last_q);
              emitted_d = 1'b1;
            end
          end else begin
            cand_d = seg_in;
            cnt_d  = 8'd1;
          end
        end
      end
      StLocked: begin
        if (seg_valid && (seg_in != cand_q)) begin
          cand_d  = seg_in;
          cnt_d   = 8'd1;
          state_d = StSettle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cand_q    <= 7'h7F;
      cnt_q     <= 8'd0;
      last_q    <= 7'h7F;
      emitted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      emitted_q <= emitted_d;
    end
  end

  logic [8:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            empty, full, pop, wr_en, drop, overflow_q;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));
  assign pop   = !empty && ascii_ready;
  // A pop on the same edge frees a slot for the push.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({wr_en, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      overflow_q <= drop || (overflow_q && !clr_overflow);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= entry;
  end

  assign ascii_valid = !empty;
  assign ascii_out   = empty ? 8'h00 : mem_q[rd_ptr_q][7:0];
  assign unknown     = !empty && mem_q[rd_ptr_q][8];
  assign overflow    = overflow_q;
  assign fifo_count  = count_q;

`ifdef DECODE_ERR_CNT_EN
  logic [7:0] err_q;

  // Counts every undecodable push, including ones dropped on a full FIFO.
  always_ff @(posedge clk) begin
    if (!reset_n || clr_overflow) begin
      err_q <= 8'd0;
    end else if (push && entry[8] && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_seg7_ascii_capture.sv
// Bench for seg7_ascii_capture: decode table vectors, directed corner sequences and
// randomized traffic checked every cycle against a queue-based reference model.
module tb_seg7_ascii_capture;

  localparam int unsigned STABLE = 4;
  localparam int unsigned DEPTH  = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] seg_in;
  logic       seg_valid;
  logic [7:0] ascii_out;
  logic       unknown;
  logic       ascii_valid;
  logic       ascii_ready;
  logic       overflow;
  logic       clr_overflow;
  logic [2:0] fifo_count;
`ifdef DECODE_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  seg7_ascii_capture #(
    .STABLE_CYCLES(STABLE),
    .DEPTH        (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .seg_in      (seg_in),
    .seg_valid   (seg_valid),
    .ascii_out   (ascii_out),
    .unknown     (unknown),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .overflow    (overflow),
    .clr_overflow(clr_overflow),
    .fifo_count  (fifo_count)
`ifdef DECODE_ERR_CNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic [7:0] asc;
    logic       unk;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  logic [8:0] mq[$];
  bit         m_ovf;
  int         run_len;
  logic [6:0] run_val;
  logic [6:0] last_acc;
  bit         have_last;
  int         m_err;

  function automatic void add(input logic [6:0] s, input logic [7:0] a, input logic u);
    vec_t v;
    v.seg = s;
    v.asc = a;
    v.unk = u;
    vecs.push_back(v);
  endfunction

  function automatic logic [8:0] ref_decode(input logic [6:0] p);
    foreach (vecs[i]) if (vecs[i].seg == p) return {vecs[i].unk, vecs[i].asc};
    return {1'b1, 8'h3F};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit         do_pop;
    bit         do_push;
    bit         drop;
    logic [8:0] ent;
    if (!reset_n) begin
      mq.delete();
      m_ovf     = 0;
      run_len   = 0;
      have_last = 0;
      m_err     = 0;
      return;
    end
    do_pop  = (mq.size() > 0) && ascii_ready;
    do_push = 0;
    drop    = 0;
    if (seg_valid) begin
      if (run_len > 0 && seg_in == run_val) begin
        if (run_len < 1000) run_len++;
      end else begin
        run_val = seg_in;
        run_len = 1;
      end
      if (run_len == STABLE) begin
        do_push   = !have_last || (run_val != last_acc);
        last_acc  = run_val;
        have_last = 1;
      end
    end
    ent = ref_decode(run_val);
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      if (mq.size() < DEPTH) mq.push_back(ent);
      else drop = 1;
    end
    if (clr_overflow) m_err = 0;
    else if (do_push && ent[8] && m_err < 255) m_err++;
    if (drop) m_ovf = 1;
    else if (clr_overflow) m_ovf = 0;
  endtask

  task automatic compare_all();
    chk("valid", 32'(ascii_valid), 32'(mq.size() != 0));
    chk("count", 32'(fifo_count), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (mq.size() != 0) begin
      chk("head_ascii", 32'(ascii_out), 32'(mq[0][7:0]));
      chk("head_unknown", 32'(unknown), 32'(mq[0][8]));
    end
`ifdef DECODE_ERR_CNT_EN
    chk("err_count", 32'(err_count), 32'(m_err));
`endif
  endtask

  // Inputs are driven after the falling edge, so they are stable at the rising edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic hold(input logic [6:0] s, input int n);
    seg_in    = s;
    seg_valid = 1'b1;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    seg_valid    = 1'b0;
    ascii_ready  = 1'b0;
    clr_overflow = 1'b0;
    tick();
    chk("rst_ascii", 32'(ascii_out), 32'h00);
    chk("rst_unknown", 32'(unknown), 32'h0);
    chk("rst_valid", 32'(ascii_valid), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    reset_n = 1'b1;
  endtask

  initial begin
    add(7'h40, 8'h30, 0); add(7'h79, 8'h31, 0); add(7'h24, 8'h32, 0); add(7'h30, 8'h33, 0);
    add(7'h19, 8'h34, 0); add(7'h12, 8'h35, 0); add(7'h02, 8'h36, 0); add(7'h78, 8'h37, 0);
    add(7'h00, 8'h38, 0); add(7'h10, 8'h39, 0); add(7'h08, 8'h41, 0); add(7'h03, 8'h42, 0);
    add(7'h46, 8'h43, 0); add(7'h21, 8'h44, 0); add(7'h06, 8'h45, 0); add(7'h0E, 8'h46, 0);
    add(7'h09, 8'h48, 0); add(7'h4F, 8'h49, 0); add(7'h61, 8'h4A, 0); add(7'h47, 8'h4C, 0);
    add(7'h6A, 8'h4D, 0); add(7'h2A, 8'h4E, 0); add(7'h0C, 8'h50, 0); add(7'h18, 8'h51, 0);
    add(7'h2F, 8'h52, 0); add(7'h07, 8'h54, 0); add(7'h41, 8'h55, 0); add(7'h63, 8'h56, 0);
    add(7'h55, 8'h57, 0); add(7'h11, 8'h59, 0); add(7'h7F, 8'h20, 0);
    add(7'h5A, 8'h3F, 1); add(7'h01, 8'h3F, 1); add(7'h7E, 8'h3F, 1);

    reset_n      = 1'b0;
    seg_in       = 7'h7F;
    seg_valid    = 1'b0;
    ascii_ready  = 1'b0;
    clr_overflow = 1'b0;
    do_reset();

    // Latency: first sample at edge 1, push at edge 4.
    seg_in    = 7'h12;
    seg_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("lat_valid_e%0d", i), 32'(ascii_valid), 32'(i == 4));
    end
    chk("lat_ascii", 32'(ascii_out), 32'h35);
    chk("lat_unknown", 32'(unknown), 32'h0);
    chk("lat_count", 32'(fifo_count), 32'd1);

    // Glitch back to the accepted pattern must not push.
    do_reset();
    hold(7'h08, 6);
    hold(7'h00, 2);
    hold(7'h08, 6);
    chk("glitch_count", 32'(fifo_count), 32'd1);
    chk("glitch_head", 32'(ascii_out), 32'h41);

    // Repeat via blank.
    do_reset();
    hold(7'h79, 4);
    hold(7'h7F, 4);
    hold(7'h79, 4);
    chk("rep_count", 32'(fifo_count), 32'd3);
    chk("rep_head0", 32'(ascii_out), 32'h31);
    seg_valid   = 1'b0;
    ascii_ready = 1'b1;
    tick();
    chk("rep_head1", 32'(ascii_out), 32'h20);
    tick();
    chk("rep_head2", 32'(ascii_out), 32'h31);
    tick();
    chk("rep_empty", 32'(ascii_valid), 32'h0);
    tick();
    chk("empty_pop_count", 32'(fifo_count), 32'd0);
    ascii_ready = 1'b0;

    // Unknown pattern.
    do_reset();
    hold(7'h5A, 4);
    chk("unk_ascii", 32'(ascii_out), 32'h3F);
    chk("unk_flag", 32'(unknown), 32'h1);
`ifdef DECODE_ERR_CNT_EN
    chk("unk_errcnt", 32'(err_count), 32'd1);
`endif

    // Table-driven decode vectors, one entry pushed then popped each.
    do_reset();
    foreach (vecs[i]) begin
      hold(vecs[i].seg, STABLE);
      chk($sformatf("tbl_valid_%0h", vecs[i].seg), 32'(ascii_valid), 32'h1);
      chk($sformatf("tbl_ascii_%0h", vecs[i].seg), 32'(ascii_out), 32'(vecs[i].asc));
      chk($sformatf("tbl_unk_%0h", vecs[i].seg), 32'(unknown), 32'(vecs[i].unk));
      ascii_ready = 1'b1;
      tick();
      ascii_ready = 1'b0;
    end

    // Overflow: five distinct patterns into a four-entry FIFO.
    do_reset();
    hold(7'h40, 4); hold(7'h79, 4); hold(7'h24, 4); hold(7'h30, 4); hold(7'h19, 4);
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk("ovf_head", 32'(ascii_out), 32'h30);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'h0);

    // Full FIFO: push and pop on the same edge.
    hold(7'h12, 3);
    ascii_ready = 1'b1;
    tick();
    ascii_ready = 1'b0;
    chk("fullpp_count", 32'(fifo_count), 32'd4);
    chk("fullpp_ovf", 32'(overflow), 32'h0);
    chk("fullpp_head", 32'(ascii_out), 32'h31);

    // Reset mid-settle with a full FIFO, then the first stable pattern must push.
    hold(7'h02, 2);
    do_reset();
    hold(7'h19, 4);
    chk("post_rst_count", 32'(fifo_count), 32'd1);
    chk("post_rst_head", 32'(ascii_out), 32'h34);

    // Randomized traffic against the model.
    for (int s = 0; s < 600; s++) begin
      logic [6:0] pat;
      int         len;
      if ($urandom_range(0, 3) == 0) pat = 7'($urandom);
      else pat = vecs[$urandom_range(0, vecs.size() - 1)].seg;
      len    = $urandom_range(1, 7);
      seg_in = pat;
      repeat (len) begin
        seg_valid    = ($urandom_range(0, 4) != 0);
        ascii_ready  = ($urandom_range(0, 2) == 0);
        clr_overflow = ($urandom_range(0, 15) == 0);
        reset_n      = ($urandom_range(0, 199) != 0);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
